mem_io_responder: RTL
=====================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 The parameter WAIT_STATES SHALL default to 2 and set the wait cycles between request capture and ready (legal range 0..15).
REQ-002 The parameter ADDR_BITS SHALL default to 8 and set the internal RAM depth to 2**ADDR_BITS 16-bit words.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 CE  input  1  active-low chip enable from the CPU.
REQ-006 OE  input  1  active-low read strobe.
REQ-007 WE  input  1  active-low write strobe.
REQ-008 ADDR  input  16  word address.
REQ-009 Data_from_CPU  input  16  write data.
REQ-010 SW  input  10  board switches, readable at 0xFFFF.
REQ-011 Data_to_CPU  output  16  registered read data.
REQ-012 R  output  1  ready: high for one cycle when the access completes.
REQ-013 HEX_DATA  output  16  display register, written at 0xFFFF, feeds the hex drivers.

Function
REQ-014 The block SHALL implement the states IDLE, WAIT, DONE and HOLD.
REQ-015 In IDLE, if CE=0 and WE=0 at an edge, the block SHALL capture a write (ADDR, Data_from_CPU) and go to WAIT.
REQ-016 In IDLE, if CE=0, OE=0 and WE=1 at an edge, the block SHALL capture a read (ADDR) and go to WAIT.
REQ-017 If OE=0 and WE=0 together, the access SHALL be treated as a write.
REQ-018 On entry to WAIT, a down-counter SHALL load WAIT_STATES.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the block SHALL go to DONE on the edge where the counter is 0.
REQ-020 With WAIT_STATES=0, the block SHALL spend exactly one cycle in WAIT.
REQ-021 R SHALL be 1 only in DONE, for exactly one cycle, which is cycle WAIT_STATES+2 after the capture edge (capture cycle = 1).
REQ-022 A write SHALL commit on the edge entering DONE.
REQ-023 Write mapping: a captured address < 2**ADDR_BITS writes RAM; 0xFFFF writes HEX_DATA; any other address is ignored but still completes with R.
REQ-024 Read data SHALL load into Data_to_CPU on the edge entering DONE.
REQ-025 Read mapping: a captured address < 2**ADDR_BITS returns the RAM word; 0xFFFF returns {6'b0, SW} sampled at that edge; any other address returns 0x0000.
REQ-026 Data_to_CPU SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-027 DONE SHALL always advance to HOLD.
REQ-028 HOLD SHALL return to IDLE on the first edge where CE=1; the block SHALL accept no new request while in HOLD.
REQ-029 If CE=1 at any edge in WAIT, the access SHALL abort to IDLE: no write commit, R stays 0, Data_to_CPU unchanged.
REQ-030 Changes on ADDR, Data_from_CPU, OE or WE after the capture edge SHALL NOT affect the access in progress.
REQ-031 Back-to-back accesses SHALL require CE to deassert for at least one cycle between them.

Reset
REQ-032 When Reset=1 at an edge, the block SHALL go to IDLE and clear R, the counter, Data_to_CPU and HEX_DATA to 0.
REQ-033 RAM contents SHALL NOT be altered by Reset.
REQ-034 Reset SHALL take priority over any state transition.
REQ-035 A write pending in WAIT when Reset asserts SHALL NOT commit.
REQ-036 Reset held across an edge SHALL keep the block in IDLE regardless of CE, OE and WE.

Verification
REQ-037 Reset, write 0x1234 to 0x0005, release CE, read 0x0005 -> R pulses once 4 cycles after each capture (WAIT_STATES=2) and Data_to_CPU=0x1234.
REQ-038 SW=10'h006, read 0xFFFF -> Data_to_CPU=0x0006; then SW=10'h00E and read again -> 0x000E.
REQ-039 Write 0xBEEF to 0xFFFF -> HEX_DATA=0xBEEF on the DONE edge; then a read of 0x8000 -> Data_to_CPU=0x0000 with R still pulsing.
REQ-040 Start a write of 0x5555 to 0x0003, raise CE in WAIT, then read 0x0003 -> no R on the aborted access and the old contents are returned.
REQ-041 Assert Reset in WAIT during a write to 0xFFFF -> HEX_DATA=0x0000, R=0, state IDLE; a later RAM read returns the pre-reset value.
REQ-042 With WAIT_STATES=0, and OE=0 and WE=0 together, writing 0x00AA to 0x0001 -> treated as a write, R one cycle after the WAIT cycle; CE held low keeps the block in HOLD with no second R.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU-side bus of the memory/IO responder: strobes, address, data, switches,
// ready pulse and the hex display register.
interface mem_io_responder_if;
  logic        CE;
  logic        OE;
  logic        WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [9:0]  SW;
  logic [15:0] Data_to_CPU;
  logic        R;
  logic [15:0] HEX_DATA;

  modport master (
    output CE, OE, WE, ADDR, Data_from_CPU, SW,
    input  Data_to_CPU, R, HEX_DATA
  );

  modport slave (
    input  CE, OE, WE, ADDR, Data_from_CPU, SW,
    output Data_to_CPU, R, HEX_DATA
  );
endinterface

// File: rtl/mem_io_responder.sv
// Wait-stated memory/IO responder: internal 16-bit RAM, a switch port and a
// hex display register at 0xFFFF, answered with a one-cycle ready pulse.
module mem_io_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_BITS   = 8
) (
  input logic Clk,
  input logic Reset,
  mem_io_responder_if.slave bus
);

  localparam int          RAM_DEPTH = 1 << ADDR_BITS;
  localparam logic [16:0] RAM_WORDS = 17'(RAM_DEPTH);
  localparam logic [15:0] IO_ADDR   = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        is_write_q;
  logic        capture;
  logic        finish;
  logic        in_ram;
  logic        r_q;
  logic [15:0] rdata_q;
  logic [15:0] hex_q;
  logic [15:0] ram [0:RAM_DEPTH-1];

  assign in_ram = ({1'b0, addr_q} < RAM_WORDS);

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.CE && (!bus.WE || !bus.OE)) begin
          capture    = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // CE dropping mid-access abandons it before anything commits
        if (bus.CE) begin
          next_state = S_IDLE;
        end else if (cnt == 4'd0) begin
          finish     = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE: next_state = S_HOLD;
      S_HOLD: begin
        if (bus.CE) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      r_q        <= 1'b0;
      rdata_q    <= 16'h0000;
      hex_q      <= 16'h0000;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      is_write_q <= 1'b0;
    end else begin
      state <= next_state;
      r_q   <= finish;
      if (capture) begin
        addr_q     <= bus.ADDR;
        wdata_q    <= bus.Data_from_CPU;
        is_write_q <= !bus.WE;
        cnt        <= 4'(WAIT_STATES);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish) begin
        if (is_write_q) begin
          if (!in_ram && addr_q == IO_ADDR) hex_q <= wdata_q;
        end else if (in_ram) begin
          rdata_q <= ram[addr_q[ADDR_BITS-1:0]];
        end else if (addr_q == IO_ADDR) begin
          rdata_q <= {6'b0, bus.SW};
        end else begin
          rdata_q <= 16'h0000;
        end
      end
    end
  end

  // RAM has no reset so its contents survive Reset
  always_ff @(posedge Clk) begin
    if (!Reset && finish && is_write_q && in_ram) begin
      ram[addr_q[ADDR_BITS-1:0]] <= wdata_q;
    end
  end

  assign bus.R           = r_q;
  assign bus.Data_to_CPU = rdata_q;
  assign bus.HEX_DATA    = hex_q;

endmodule
